char_rom_arbiter: RTL

Shares one synchronous character/sprite ROM between the host-character and guest-character draw pipelines of the two-player VGA renderer (1024x768). Each cycle it grants one read request with round-robin fairness and drives the ROM address. It tracks in-flight reads through a tag pipeline and routes the returned pixel word back to the requester that issued it. Priority is re-armed to the host side at every frame start, so both characters fetch deterministically.

---
 rtl/char_rom_arbiter.sv | 100 ++++++++++
 1 files changed

// File: rtl/char_rom_arbiter.sv
// Round-robin arbiter sharing one synchronous char/sprite ROM between host and guest draw pipelines.
// Latency: grant is combinational, rom_en/rom_addr one edge later, rvalid ROM_LATENCY+1 edges after acceptance.
// Backpressure: none on returns; a losing requester holds req/addr until granted (bounded to 2 cycles).
module char_rom_arbiter #(
    parameter int unsigned ADDR_WIDTH  = 12,
    parameter int unsigned DATA_WIDTH  = 12,
    parameter int unsigned ROM_LATENCY = 1
) (
    input  logic                  clk,
    input  logic                  rst,
    input  logic                  frame_start,
    input  logic                  req_host,
    input  logic [ADDR_WIDTH-1:0] addr_host,
    output logic                  gnt_host,
    output logic                  rvalid_host,
    output logic [DATA_WIDTH-1:0] rdata_host,
    input  logic                  req_guest,
    input  logic [ADDR_WIDTH-1:0] addr_guest,
    output logic                  gnt_guest,
    output logic                  rvalid_guest,
    output logic [DATA_WIDTH-1:0] rdata_guest,
    output logic                  rom_en,
    output logic [ADDR_WIDTH-1:0] rom_addr,
    input  logic [DATA_WIDTH-1:0] rom_data
);

    localparam int unsigned TAG_DEPTH = ROM_LATENCY + 1;

    typedef struct packed {
        logic vld;
        logic own;   // 0 = host, 1 = guest
    } tag_t;

    logic prio;
    logic accept;
    tag_t tag_pipe [TAG_DEPTH];
    tag_t tag_out;

    assign gnt_host  = req_host  & (~req_guest | ~prio);
    assign gnt_guest = req_guest & (~req_host  |  prio);
    assign accept    = gnt_host | gnt_guest;
    assign tag_out   = tag_pipe[TAG_DEPTH-1];

    // Frame start re-arms host priority and overrides the rotation from a same-cycle grant.
    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            prio <= 1'b0;
        end else if (frame_start) begin
            prio <= 1'b0;
        end else if (accept) begin
            prio <= gnt_host;
        end
    end

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            rom_en   <= 1'b0;
            rom_addr <= '0;
        end else begin
            rom_en <= accept;
            if (accept) begin
                rom_addr <= gnt_host ? addr_host : addr_guest;
            end
        end
    end

    // Owner tags ride alongside the ROM pipeline; clearing them on reset drops in-flight returns.
    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            for (int i = 0; i < int'(TAG_DEPTH); i++) begin
                tag_pipe[i] <= '0;
            end
        end else begin
            tag_pipe[0].vld <= accept;
            tag_pipe[0].own <= gnt_guest;
            for (int i = 1; i < int'(TAG_DEPTH); i++) begin
                tag_pipe[i] <= tag_pipe[i-1];
            end
        end
    end

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            rvalid_host  <= 1'b0;
            rvalid_guest <= 1'b0;
            rdata_host   <= '0;
            rdata_guest  <= '0;
        end else begin
            rvalid_host  <= tag_out.vld & ~tag_out.own;
            rvalid_guest <= tag_out.vld &  tag_out.own;
            if (tag_out.vld && !tag_out.own) begin
                rdata_host <= rom_data;
            end
            if (tag_out.vld && tag_out.own) begin
                rdata_guest <= rom_data;
            end
        end
    end

endmodule
